smi_transaction_throttle: RTL

- Stage directly downstream of the three-way scaled transaction arbiter, on the double-width SMI bus, between the arbiter and the memory interface.
- Limits the number of request frames in flight to the memory system, so the per-port response frame buffers cannot be overrun.
- Request and response paths each pass through a registered two-entry skid buffer.
- Tracks outstanding transactions by counting frame starts issued and response frame ends returned.

---
 rtl/smi_transaction_throttle.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/smi_transaction_throttle.sv
// ---------------------------------------------------------------------------
// smi_transaction_throttle
//
// Sits between the scaled transaction arbiter and the memory interface on the
// double-width SMI bus. It caps the number of request frames in flight so the
// per-port response frame buffers upstream can never be overrun. Request and
// response paths each pass through a registered two-entry skid buffer.
// Frames in flight are counted as frame starts issued minus response frame
// ends returned. New frames are only held off at a frame boundary, so a frame
// that has started always completes.
//
// Ports
//   clk, srst                 clock, synchronous active-high reset
//   smiReqIn*  (Ready/Eofc/Data in, Stop out)    request from arbiter
//   smiReqOut* (Ready/Eofc/Data out, Stop in)    request to memory
//   smiRespIn* (Ready/Eofc/Data in, Stop out)    response from memory
//   smiRespOut*(Ready/Eofc/Data out, Stop in)    response to arbiter
//   outstandingCount          registered count of request frames in flight
//   underflowError            sticky: response frame end seen at count 0
// A flit moves when Ready=1 and Stop=0 in the same cycle. Eofc=0 marks a
// mid-frame flit; nonzero marks the last flit and gives its byte count.
// ---------------------------------------------------------------------------
module smi_transaction_throttle #(
  parameter int FlitWidth      = 8,
  parameter int MaxOutstanding = 16,
  parameter int DataWidth      = FlitWidth * 8,
  parameter int CountWidth     = 8
) (
  input  logic                  clk,
  input  logic                  srst,
  input  logic                  smiReqInReady,
  input  logic [7:0]            smiReqInEofc,
  input  logic [DataWidth-1:0]  smiReqInData,
  output logic                  smiReqInStop,
  output logic                  smiReqOutReady,
  output logic [7:0]            smiReqOutEofc,
  output logic [DataWidth-1:0]  smiReqOutData,
  input  logic                  smiReqOutStop,
  input  logic                  smiRespInReady,
  input  logic [7:0]            smiRespInEofc,
  input  logic [DataWidth-1:0]  smiRespInData,
  output logic                  smiRespInStop,
  output logic                  smiRespOutReady,
  output logic [7:0]            smiRespOutEofc,
  output logic [DataWidth-1:0]  smiRespOutData,
  input  logic                  smiRespOutStop,
  output logic [CountWidth-1:0] outstandingCount,
  output logic                  underflowError
);

  localparam int ReqPath  = 0;
  localparam int RespPath = 1;
  localparam logic [CountWidth-1:0] CountMax = CountWidth'(MaxOutstanding);

  typedef struct packed {
    logic [7:0]           eofc;
    logic [DataWidth-1:0] data;
  } flit_t;

  typedef enum logic {
    IDLE = 1'b0,  // next accepted request flit starts a frame
    BODY = 1'b1   // inside a request frame; never throttled
  } state_e;

  // Index 0 is the request path, index 1 the response path.
  flit_t      in_flit      [2];
  flit_t      head_q       [2];  // entry presented downstream
  flit_t      skid_q       [2];  // second entry, parked while head is stalled
  logic [1:0] in_ready;
  logic [1:0] in_stop;
  logic [1:0] out_stop;
  logic [1:0] accept;
  logic [1:0] drain;
  logic [1:0] head_valid_q;
  logic [1:0] skid_valid_q;
  logic [1:0] full_q;

  state_e                state_q;
  state_e                state_next;
  logic                  in_frame;
  logic                  throttle;
  logic                  incr;
  logic                  decr;
  logic [CountWidth-1:0] count_q;
  logic                  underflow_q;

  assign in_frame = (state_q == BODY);

  // Handshake qualification for both skid buffers.
  always_comb begin
    // NOTE: every always_comb output gets a default before any branch so no
    // path can leave it unassigned and infer a latch.
    in_flit[ReqPath]  = '{eofc: smiReqInEofc,  data: smiReqInData};
    in_flit[RespPath] = '{eofc: smiRespInEofc, data: smiRespInData};
    in_ready          = {smiRespInReady, smiReqInReady};
    out_stop          = {smiRespOutStop, smiReqOutStop};
    // Throttle looks only at registered state: a frame start freed by a
    // response end becomes acceptable the cycle after the count drops.
    throttle          = ~in_frame & (count_q == CountMax);
    in_stop[ReqPath]  = srst | full_q[ReqPath] | throttle;
    in_stop[RespPath] = srst | full_q[RespPath];
    accept            = in_ready & ~in_stop;
    drain             = head_valid_q & ~out_stop;
  end

  // Two-entry skid buffers. full_q is the registered input Stop: it is set
  // when occupancy after this edge will be two, which only happens when the
  // head is stalled and either the skid entry is already taken or a flit is
  // being accepted into it.
  always_ff @(posedge clk) begin
    if (srst) begin
      head_valid_q <= '0;
      skid_valid_q <= '0;
      full_q       <= '0;
      // NOTE: the data registers are reset too because the downstream Data
      // and Eofc outputs must read zero out of reset; only the valid bits
      // would otherwise need it.
      for (int p = 0; p < 2; p++) begin
        head_q[p] <= '0;
        skid_q[p] <= '0;
      end
    end else begin
      for (int p = 0; p < 2; p++) begin
        full_q[p] <= head_valid_q[p] & ~drain[p] & (skid_valid_q[p] | accept[p]);
        if (drain[p]) begin
          if (skid_valid_q[p]) begin
            head_q[p]       <= skid_q[p];
            skid_valid_q[p] <= 1'b0;
          end else if (accept[p]) begin
            head_q[p] <= in_flit[p];
          end else begin
            head_valid_q[p] <= 1'b0;
          end
        end else if (accept[p]) begin
          if (head_valid_q[p]) begin
            skid_q[p]       <= in_flit[p];
            skid_valid_q[p] <= 1'b1;
          end else begin
            head_q[p]       <= in_flit[p];
            head_valid_q[p] <= 1'b1;
          end
        end
      end
    end
  end

  // Request frame tracking: state register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every register
    // samples the pre-edge values regardless of statement order.
    if (srst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_next;
    end
  end

  // Request frame tracking: next state and frame-start pulse.
  always_comb begin
    state_next = state_q;
    incr       = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept[ReqPath]) begin
          incr = 1'b1;
          if (smiReqInEofc == 8'd0) begin
            state_next = BODY;
          end
        end
      end
      BODY: begin
        if (accept[ReqPath] && (smiReqInEofc != 8'd0)) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // A response frame retires one outstanding request when its last flit
  // leaves towards the arbiter.
  assign decr = drain[RespPath] & (head_q[RespPath].eofc != 8'd0);

  always_ff @(posedge clk) begin
    if (srst) begin
      count_q     <= '0;
      underflow_q <= 1'b0;
    end else if (incr && !decr) begin
      count_q <= count_q + CountWidth'(1);
    end else if (decr && !incr) begin
      if (count_q == '0) begin
        underflow_q <= 1'b1;  // count saturates at zero
      end else begin
        count_q <= count_q - CountWidth'(1);
      end
    end
  end

  assign smiReqInStop     = in_stop[ReqPath];
  assign smiReqOutReady   = head_valid_q[ReqPath];
  assign smiReqOutEofc    = head_q[ReqPath].eofc;
  assign smiReqOutData    = head_q[ReqPath].data;
  assign smiRespInStop    = in_stop[RespPath];
  assign smiRespOutReady  = head_valid_q[RespPath];
  assign smiRespOutEofc   = head_q[RespPath].eofc;
  assign smiRespOutData   = head_q[RespPath].data;
  assign outstandingCount = count_q;
  assign underflowError   = underflow_q;

endmodule
